// File: rtl/fp_convert_pkg.sv
// fp_convert_pkg
//   Shared widths, controller state encoding and the intermediate result
//   record passed from the encode stage to the rounding stage of
//   fp_convert_arbiter.
//   No ports (package).

package fp_convert_pkg;

  localparam int NUM_W = 12;  // input sample width, two's complement
  localparam int EXP_W = 3;   // exponent width
  localparam int SIG_W = 4;   // significand width

  // Largest representable magnitude; the most negative input clamps here.
  localparam logic [NUM_W-1:0] MAG_MAX = {1'b0, {(NUM_W-1){1'b1}}};
  localparam logic [NUM_W-1:0] NUM_MIN = {1'b1, {(NUM_W-1){1'b0}}};

  // Significand value after a rounding carry renormalises (1000b).
  localparam logic [SIG_W-1:0] SIG_CARRY = {1'b1, {(SIG_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_ROUND = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             fifth;  // first bit below the kept significand
  } fp_result_t;

endpackage

// File: rtl/fp_encode.sv
// fp_encode
//   Combinational front half of the converter: takes a two's-complement
//   sample, forms its magnitude (most negative value clamps to MAG_MAX),
//   counts leading zeros and extracts the exponent, the 4-bit significand
//   and the next lower bit used later for round-to-nearest.
// Ports:
//   i_num    in   NUM_W  sample
//   o_sign   out  1      sign of the sample
//   o_exp    out  EXP_W  exponent (shift applied to the magnitude)
//   o_sig    out  SIG_W  truncated significand
//   o_fifth  out  1      bit just below the significand (0 when exp=0)

module fp_encode
  import fp_convert_pkg::*;
(
  input  logic [NUM_W-1:0] i_num,
  output logic             o_sign,
  output logic [EXP_W-1:0] o_exp,
  output logic [SIG_W-1:0] o_sig,
  output logic             o_fifth
);

  // lz at or above this means the magnitude already fits in SIG_W bits.
  localparam logic [3:0] LZ_SMALL = 4'(NUM_W - SIG_W);

  logic [NUM_W-1:0] w_mag;
  logic [3:0]       w_lz;
  logic [3:0]       w_pos;

  assign o_sign = i_num[NUM_W-1];

  always_comb begin
    if (i_num == NUM_MIN) begin
      w_mag = MAG_MAX;
    end else if (i_num[NUM_W-1]) begin
      w_mag = -i_num;
    end else begin
      w_mag = i_num;
    end
  end

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    w_lz = 4'(NUM_W);
    for (int i = 0; i < NUM_W; i++) begin
      if (w_mag[i]) begin
        w_lz = 4'(NUM_W - 1 - i);
      end
    end
  end

  always_comb begin
    o_exp   = '0;
    o_sig   = w_mag[SIG_W-1:0];
    o_fifth = 1'b0;
    w_pos   = '0;
    if (w_lz < LZ_SMALL) begin
      // Magnitude never exceeds MAG_MAX, so lz>=1 and exp stays within 1..7.
      w_pos   = LZ_SMALL - w_lz;
      o_exp   = EXP_W'(w_pos);
      o_sig   = w_mag[w_pos +: SIG_W];
      o_fifth = w_mag[w_pos - 4'd1];
    end
  end

endmodule

// File: rtl/fp_convert_arbiter.sv
// fp_convert_arbiter
//   Shares one fixed-to-float encoder between two requesters. A round-robin
//   arbiter grants one sample in IDLE; the sample is encoded (CONV), rounded
//   to nearest (ROUND) and presented with its requester id on a valid/ready
//   response port (RESP). One sample is in flight at a time.
// Ports:
//   i_clk          in   1      rising-edge clock
//   i_rst          in   1      asynchronous active-high reset
//   i_req0_valid   in   1      requester 0 has a sample
//   i_req0_num     in   NUM_W  requester 0 sample
//   o_req0_ready   out  1      requester 0 accepted when valid&ready
//   i_req1_valid   in   1      requester 1 has a sample
//   i_req1_num     in   NUM_W  requester 1 sample
//   o_req1_ready   out  1      requester 1 accepted when valid&ready
//   o_rsp_valid    out  1      result available
//   i_rsp_ready    in   1      consumer accepts result
//   o_rsp_id       out  1      requester owning the result
//   o_rsp_sign     out  1      sign
//   o_rsp_exp      out  EXP_W  exponent
//   o_rsp_sig      out  SIG_W  significand; value = sig * 2^exp
//   o_busy         out  1      controller not in IDLE
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for a request; grant visible on reqN_ready
// S_CONV  | captured sample goes through fp_encode; fields registered
// S_ROUND | round-to-nearest applied; response registered
// S_RESP  | response held until rsp_ready

module fp_convert_arbiter
  import fp_convert_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  input  logic [NUM_W-1:0] i_req0_num,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [NUM_W-1:0] i_req1_num,
  output logic             o_req1_ready,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic             o_rsp_sign,
  output logic [EXP_W-1:0] o_rsp_exp,
  output logic [SIG_W-1:0] o_rsp_sig,
  output logic             o_busy
);

  state_t           r_state;
  logic             r_last_grant;
  logic [NUM_W-1:0] r_num;
  logic             r_id;
  fp_result_t       r_enc;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic             r_rsp_sign;
  logic [EXP_W-1:0] r_rsp_exp;
  logic [SIG_W-1:0] r_rsp_sig;

  logic             w_idle;
  logic             w_grant_valid;
  logic             w_grant;
  logic             w_accept;
  logic [NUM_W-1:0] w_sel_num;
  fp_result_t       w_enc;
  logic [EXP_W-1:0] w_rnd_exp;
  logic [SIG_W-1:0] w_rnd_sig;

  fp_encode u_encode (
    .i_num   (r_num),
    .o_sign  (w_enc.sign),
    .o_exp   (w_enc.exp),
    .o_sig   (w_enc.sig),
    .o_fifth (w_enc.fifth)
  );

  // Round-robin: on a tie the requester not granted last wins.
  always_comb begin
    w_grant_valid = i_req0_valid | i_req1_valid;
    if (i_req0_valid & i_req1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = i_req1_valid;
    end
  end

  assign w_idle       = (r_state == S_IDLE);
  assign o_req0_ready = w_idle & w_grant_valid & ~w_grant & ~i_rst;
  assign o_req1_ready = w_idle & w_grant_valid &  w_grant & ~i_rst;
  assign w_accept     = (o_req0_ready & i_req0_valid) | (o_req1_ready & i_req1_valid);
  assign w_sel_num    = w_grant ? i_req1_num : i_req0_num;

  // Round to nearest; a carry out of the significand renormalises to 1000b
  // and bumps the exponent, saturating at the largest code.
  always_comb begin
    w_rnd_exp = r_enc.exp;
    w_rnd_sig = r_enc.sig;
    if (r_enc.fifth) begin
      if (r_enc.sig != '1) begin
        w_rnd_sig = r_enc.sig + SIG_W'(1);
      end else if (r_enc.exp != '1) begin
        w_rnd_sig = SIG_CARRY;
        w_rnd_exp = r_enc.exp + EXP_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_num        <= '0;
      r_id         <= 1'b0;
      r_enc        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_sign   <= 1'b0;
      r_rsp_exp    <= '0;
      r_rsp_sig    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_num        <= w_sel_num;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= S_CONV;
          end
        end
        S_CONV: begin
          r_enc   <= w_enc;
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_rsp_id    <= r_id;
          r_rsp_sign  <= r_enc.sign;
          r_rsp_exp   <= w_rnd_exp;
          r_rsp_sig   <= w_rnd_sig;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_sign  = r_rsp_sign;
  assign o_rsp_exp   = r_rsp_exp;
  assign o_rsp_sig   = r_rsp_sig;
  assign o_busy      = ~w_idle;

endmodule

// File: tb/tb_fp_convert_arbiter.sv
// tb_fp_convert_arbiter
//   Self-checking bench for fp_convert_arbiter. Expected responses come from
//   a behavioural model and are queued at accept time, then compared when
//   the DUT presents its response.

module tb_fp_convert_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [11:0] req0_num, req1_num;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_ready;
  logic        rsp_id, rsp_sign;
  logic [2:0]  rsp_exp;
  logic [3:0]  rsp_sig;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] sb[$];  // {id, sign, exp[2:0], sig[3:0]}

  always #5 clk = ~clk;

  fp_convert_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_valid (req0_valid),
    .i_req0_num   (req0_num),
    .o_req0_ready (req0_ready),
    .i_req1_valid (req1_valid),
    .i_req1_num   (req1_num),
    .o_req1_ready (req1_ready),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_sign   (rsp_sign),
    .o_rsp_exp    (rsp_exp),
    .o_rsp_sig    (rsp_sig),
    .o_busy       (busy)
  );

  // Behavioural model: shift right until the magnitude fits in 4 bits,
  // then round half-up on the first dropped bit.
  function automatic logic [8:0] model(input logic id, input logic [11:0] num);
    int v, m, e, s, f;
    logic sgn;
    v   = $signed(num);
    sgn = (v < 0);
    m   = sgn ? -v : v;
    if (m > 2047) m = 2047;
    e = 0;
    f = 0;
    if (m < 16) begin
      s = m;
    end else begin
      while ((m >> e) >= 16) e++;
      s = (m >> e) & 15;
      f = (m >> (e - 1)) & 1;
    end
    if (f == 1) begin
      if (s < 15) s++;
      else if (e < 7) begin s = 8; e++; end
    end
    return {id, sgn, 3'(e), 4'(s)};
  endfunction

  function automatic logic [8:0] rsp_word();
    return {rsp_id, rsp_sign, rsp_exp, rsp_sig};
  endfunction

  // One request from an idle DUT through to its handshake, checked inline.
  task automatic send_and_check(input logic id, input logic [11:0] num, input string tag);
    int t;
    logic [8:0] exp_v, got;
    if (id) begin req1_valid = 1'b1; req1_num = num; end
    else    begin req0_valid = 1'b1; req0_num = num; end
    #1;
    t = 0;
    while (!(id ? req1_ready : req0_ready) && t < 20) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (t >= 20) begin
      $display("FAIL %s accept: ready never seen within 20 cycles", tag);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    n_pass++;
    sb.push_back(model(id, num));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (t !== 2) $display("FAIL %s latency: got %0d cycles, want 2", tag, t);
    else n_pass++;
    if (!rsp_valid) begin void'(sb.pop_front()); return; end
    exp_v = sb.pop_front();
    got   = rsp_word();
    n_checks++;
    if (got !== exp_v) $display("FAIL %s result: got %h want %h", tag, got, exp_v);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL %s after handshake: busy=%b rsp_valid=%b want 0 0", tag, busy, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_num = 12'h123; req1_num = 12'h456;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset ctrl: rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    else n_pass++;
    n_checks++;
    if (rsp_word() !== 9'h000) $display("FAIL reset rsp: got %h want 000", rsp_word());
    else n_pass++;
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      $display("FAIL reset ready: got %b%b want 00", req0_ready, req1_ready);
    else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL idle after reset: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_vectors();
    logic [11:0] nums[6] = '{12'h1A6, 12'h0F8, 12'h7FF, 12'h800, 12'hFFF, 12'h000};
    logic        ids[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) send_and_check(ids[i], nums[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 8; i++)
      send_and_check(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                     $sformatf("rand%0d", i));
  endtask

  task automatic test_round_robin();
    logic [11:0] s0[3] = '{12'h1A6, 12'h123, 12'hF00};
    logic [11:0] s1[3] = '{12'h0F8, 12'h7FF, 12'h801};
    int i0, i1, nacc, nrsp, cyc;
    logic got_id, acc;
    logic [8:0] exp_v;
    i0 = 0; i1 = 0; nacc = 0; nrsp = 0; cyc = 0;
    req0_valid = 1'b1; req0_num = s0[0];
    req1_valid = 1'b1; req1_num = s1[0];
    rsp_ready  = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL rr first tie: ready=%b%b want 10 (req0 wins)", req0_ready, req1_ready);
    else n_pass++;
    while (nrsp < 6 && cyc < 100) begin
      if (rsp_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL rr response: unexpected response %h", rsp_word());
        end else begin
          exp_v = sb.pop_front();
          if (rsp_word() !== exp_v) $display("FAIL rr response %0d: got %h want %h", nrsp, rsp_word(), exp_v);
          else n_pass++;
        end
        nrsp++;
      end
      acc = 1'b0; got_id = 1'b0;
      if (req0_valid && req0_ready) begin acc = 1'b1; got_id = 1'b0; end
      else if (req1_valid && req1_ready) begin acc = 1'b1; got_id = 1'b1; end
      if (acc) begin
        n_checks++;
        if (got_id !== 1'(nacc % 2)) $display("FAIL rr order %0d: got id %0d want %0d", nacc, got_id, nacc % 2);
        else n_pass++;
        if (got_id) begin sb.push_back(model(1'b1, s1[i1])); i1++; end
        else        begin sb.push_back(model(1'b0, s0[i0])); i0++; end
        nacc++;
      end
      @(posedge clk); #1;
      cyc++;
      req0_valid = (i0 < 3); if (i0 < 3) req0_num = s0[i0];
      req1_valid = (i1 < 3); if (i1 < 3) req1_num = s1[i1];
    end
    n_checks++;
    if (nrsp < 6) $display("FAIL rr completion: got %0d responses want 6", nrsp);
    else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int t;
    logic [8:0] exp_v;
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_num = 12'h5A5;
    #1;
    t = 0;
    while (!req0_ready && t < 20) begin @(posedge clk); #1; t++; end
    sb.push_back(model(1'b0, 12'h5A5));
    @(posedge clk); #1;
    req0_num = 12'h0AA;
    req1_valid = 1'b1; req1_num = 12'h010;
    t = 0;
    while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (!rsp_valid) $display("FAIL bp response: rsp_valid never rose");
    else n_pass++;
    exp_v = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (rsp_word() !== exp_v || rsp_valid !== 1'b1 || req0_ready !== 1'b0 ||
          req1_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL bp hold %0d: rsp=%h v=%b rdy=%b%b busy=%b want %h 1 00 1",
                 k, rsp_word(), rsp_valid, req0_ready, req1_ready, busy, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b1)
      $display("FAIL bp release: busy=%b v=%b rdy=%b%b want 0 0 01",
               busy, rsp_valid, req0_ready, req1_ready);
    else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL bp dropped request: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int t, seen;
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_num = 12'h3FF;
    #1;
    t = 0;
    while (!req0_ready && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL midrst pre: busy=%b want 1", busy);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
      $display("FAIL midrst async: busy=%b v=%b rdy=%b%b want 0 0 00",
               busy, rsp_valid, req0_ready, req1_ready);
    else n_pass++;
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL midrst discard: rsp_valid high %0d cycles want 0", seen);
    else n_pass++;
    send_and_check(1'b1, 12'h0F8, "after_reset");
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_num = '0; req1_num = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_vectors();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/fp_convert_arbiter.md
# fp_convert_arbiter

Shares one floating-point encoder between two requesters. Each requester submits a 12-bit two's-complement sample. The block arbitrates round-robin, runs the conversion to sign / 3-bit exponent / 4-bit significand over two registered stages (encode, then round-to-nearest), and returns the result with the requester ID over a valid/ready response port. It sits between the sample sources and the display/consumer logic of the lab datapath.

## Interface
- NUM_W, 12, input sample width (two's complement)
- EXP_W, 3, exponent width
- SIG_W, 4, significand width
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- req0_valid  in  1  requester 0 has a sample
- req0_num  in  NUM_W  requester 0 sample
- req0_ready  out  1  requester 0 sample accepted this cycle when valid&ready
- req1_valid / req1_num / req1_ready  same, requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that owns the result
- rsp_sign  out  1  sign bit
- rsp_exp  out  EXP_W  exponent
- rsp_sig  out  SIG_W  significand; value = rsp_sig * 2^rsp_exp
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states are IDLE, CONV, ROUND and RESP.
- IDLE: the grant goes to the valid requester. If both requesters are valid, the grant goes to the one not granted last (last_grant pointer). reqN_ready = (state==IDLE) & grant==N & !rst. On accept, capture the sample and ID, update last_grant, and go to CONV.
- CONV: sign = num[11]. mag = |num|, but -2048 clamps to 2047. lz = leading zeros of the 12-bit mag, counted from bit 11. If lz≥8, then exp=0, sig=mag[3:0] and fifth=0. Otherwise exp=8-lz, sig=mag[exp+3:exp] and fifth=mag[exp-1]. Register sign, exp, sig and fifth, then go to ROUND.
- ROUND: if fifth=0, keep the values unchanged. If fifth=1 and sig<15, then sig+1. If fifth=1, sig=15 and exp<7, then sig=8 and exp+1. If fifth=1, sig=15 and exp=7, saturate to exp=7, sig=15. Register the rsp_* outputs, set rsp_valid, and go to RESP.
- RESP: rsp_* outputs are held stable while rsp_ready=0. On rsp_valid&rsp_ready, clear rsp_valid and go to IDLE. No request is accepted in RESP.
- Zero input gives sign=0, exp=0, sig=0.
- Reset, including mid-operation: state=IDLE, rsp_valid=0, rsp_id/sign/exp/sig=0, last_grant=1 (requester 0 wins the first tie), busy=0. The in-flight sample is discarded and no response is produced.

## Timing
- Accept at edge t0 puts the FSM in CONV. Edge t1 puts it in ROUND. At edge t2, rsp_valid=1 and the result is valid. Latency is two clocks from the accept edge to the response.
- The earliest next accept is one cycle after the response handshake. Peak throughput is one sample per 4 cycles.
- reqN_ready is combinational from state and the arbiter. It must not depend on rsp_ready.
- A request that drops valid before ready is simply not served. A requester that is not granted keeps its valid asserted and sees ready=0.

## Structure
- Package fp_convert_pkg holds NUM_W/EXP_W/SIG_W, the state enum, and a result struct {sign, exp, sig, fifth}.
- Sub-module fp_encode is combinational. It performs magnitude, clamp, leading-zero count and field extraction. The controller registers its outputs in CONV. Rounding and the FSM stay in the top block.

## Test plan
- req0 = 422 (0x1A6) -> rsp_id=0, sign=0, exp=5, sig=13; rsp_valid rises 2 clocks after accept.
- req1 = 248 (0x0F8) -> rounding carry: exp=5, sig=8. req1 = 2047 -> saturate: exp=7, sig=15. req1 = -2048 -> sign=1, exp=7, sig=15. req1 = -1 -> sign=1, exp=0, sig=1.
- req0 = 0 -> sign=0, exp=0, sig=0.
- Both requesters valid from reset, each with 3 samples -> accept order and rsp_id alternate 0,1,0,1,0,1.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both readys 0, busy=1; release -> IDLE next cycle.
- Assert rst for 1 cycle while in ROUND -> rsp_valid stays 0, busy=0 immediately, no response for that sample; the next request completes normally.
